mc_clock_strobe_gen: RTL and testbench
======================================

// Module: mc_clock_strobe_gen
// PURPOSE
//   Upstream feeder for the FD-class flip-flop cells. Samples the netlist's derived
//   clocks on MasterClock, glitch-filters them, and emits one-MasterClock-cycle rise/fall
//   strobes that FD cells use as edge enables. Also contains a programmable MasterClock
//   divider that produces an internal phase clock with its own strobes.
//   Lets the gate-level model run single-clock without losing edge semantics.
// PARAMETERS
//   N_CLK        4   number of sampled netlist clock inputs
//   SYNC_STAGES  2   synchroniser depth per input (>=2)
//   FILTER       2   consecutive agreeing synced samples required to accept a level change (>=1)
//   DIV_W        4   width of the divider reload value
// PORTS
//   MasterClock  in   1        sole clock; all state changes on its posedge
//   reset        in   1        asynchronous, active-high; clears all state immediately
//   clkIn        in   N_CLK    netlist clocks, asynchronous to MasterClock
//   enable       in   1        1 = divider runs; 0 = divider frozen, div strobes forced 0
//   divLoad      in   1        1-cycle pulse: capture divValue into shadow reload register
//   divValue     in   DIV_W    half-period minus 1, in MasterClock cycles
//   clkLvl       out  N_CLK    filtered level of each clkIn
//   rise         out  N_CLK    1-cycle strobe on accepted 0->1 change
//   fall         out  N_CLK    1-cycle strobe on accepted 1->0 change
//   divClk       out  1        divided phase clock level
//   divRise      out  1        1-cycle strobe on divClk 0->1
//   divFall      out  1        1-cycle strobe on divClk 1->0
//   glitchCount  out  8        saturating count of rejected pulses, all channels
// BEHAVIOUR
//   Reset values: sync chains 0, clkLvl 0, rise/fall 0, filter counters 0, divClk 0,
//     div strobes 0, divider counter 0, shadow reload 0, glitchCount 0.
//   Reset is asserted mid-operation with immediate effect. No strobe is emitted on reset release.
//   Sampling (per channel): sample s = last sync stage. If s != clkLvl, increment the
//     agree counter. If s == clkLvl, clear the agree counter.
//   When the agree counter reaches FILTER: clkLvl <= s, agree counter <= 0, and rise or fall
//     is pulsed for exactly the following cycle.
//   Latency: a clean clkIn edge gives a strobe SYNC_STAGES+FILTER cycles later (default 4).
//   Glitch: if the agree counter is nonzero and s returns to clkLvl, glitchCount increments.
//     glitchCount saturates at 255.
//     Several channels glitching in one cycle add their count; the total clamps at 255.
//   Channels are independent. Simultaneous strobes on several channels are legal.
//   Divider states: ACTIVE (enable=1) and FROZEN (enable=0).
//     ACTIVE, counter != 0: counter decrements.
//     ACTIVE, counter == 0: counter <= shadow, divClk toggles, divRise/divFall pulses.
//     FROZEN: counter and divClk hold; divRise/divFall are 0.
//   Shadow = 0 gives a divClk toggle every cycle (period 2).
//     Shadow = 2^DIV_W-1 gives period 2^(DIV_W+1).
//   divLoad writes the shadow only. It takes effect at the next terminal count, never
//     mid-half-period.
//   divLoad in the same cycle as a terminal count: the reload uses the OLD shadow.
//     The new value applies from the following reload.
//   After reset, the first terminal count occurs on the first enabled cycle.
//     So the first divRise occurs 1 cycle after enable rises.
// STRUCTURE
//   Package mc_clk_pkg:
//     - typedef for the filter counter width $clog2(FILTER+1)
//     - glitch saturation constant 8'hFF
//     - typedef for the divider state enum (ACTIVE/FROZEN)
//   Sub-module mc_edge_filter: one synchroniser plus filter plus strobe per channel,
//     outputs lvl, rise, fall, glitch. Instantiate it N_CLK times with generate.
//   Glitch accumulation and the divider live in the top level.
// TESTING
//   1. Reset, then clkIn[0] 0->1 held -> rise[0]=1 for one cycle exactly 4 cycles later;
//      clkLvl[0]=1 thereafter; glitchCount=0.
//   2. clkIn[1] high for 1 synced cycle (FILTER=2) -> no rise/fall, clkLvl[1] stays 0,
//      glitchCount=1. Repeat 300 times -> glitchCount=255.
//   3. divLoad with divValue=3, enable=1 -> divClk period 8 cycles. Each divRise/divFall is
//      1 cycle wide and they alternate every 4 cycles.
//   4. divLoad with divValue=0 mid-count on a divValue=3 run -> the current half-period
//      completes at 4 cycles, then the period becomes 2.
//   5. enable dropped for 5 cycles mid-count -> divClk and counter hold, no div strobes.
//      Counting resumes with the remaining count.
//   6. reset asserted while rise[2] pending and divClk=1 -> all outputs 0 immediately.
//      No strobes in the first cycle after release.

Source files
------------

// File: rtl/mc_clk_pkg.sv
// Shared types and constants for the MasterClock strobe generator.
// Filter counter sizing, glitch saturation limit and divider state encoding.
package mc_clk_pkg;

   localparam int         FILTER_DEF = 2;
   localparam logic [7:0] GLITCH_SAT = 8'hFF;

   typedef logic [$clog2(FILTER_DEF+1)-1:0] filtCnt_t;

   typedef enum logic {
      ACTIVE = 1'b0,
      FROZEN = 1'b1
   } divState_t;

   // Agree-counter width for a given filter depth; never narrower than one bit.
   function automatic int filtCntW(input int filter);
      return (filter < 1) ? 1 : $clog2(filter + 1);
   endfunction

endpackage

// File: rtl/mc_edge_filter.sv
// One netlist-clock channel: synchroniser, agreement filter, and rise/fall strobes.
// glitch is combinational and flags a sample that returns to the accepted level mid-filter.
module mc_edge_filter
   import mc_clk_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall,
   output logic glitch
);

   localparam int               CNT_W    = filtCntW(FILTER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

   logic [SYNC_STAGES-1:0] syncChain;
   logic [CNT_W-1:0]       agreeCnt;
   logic                   s;

   assign s      = syncChain[SYNC_STAGES-1];
   assign glitch = (agreeCnt != '0) && (s == lvl);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncChain <= '0;
         agreeCnt  <= '0;
         lvl       <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         syncChain <= {syncChain[SYNC_STAGES-2:0], din};
         rise      <= 1'b0;
         fall      <= 1'b0;
         if (s != lvl) begin
            // The FILTER-th disagreeing sample commits the new level.
            if (agreeCnt == CNT_LAST) begin
               lvl      <= s;
               agreeCnt <= '0;
               rise     <= s;
               fall     <= ~s;
            end else begin
               agreeCnt <= agreeCnt + 1'b1;
            end
         end else begin
            agreeCnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mc_clock_strobe_gen.sv
// Samples netlist clocks on MasterClock and emits filtered level plus edge strobes,
// and a programmable MasterClock divider with its own phase strobes.
module mc_clock_strobe_gen
   import mc_clk_pkg::*;
#(
   parameter int N_CLK       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 2,
   parameter int DIV_W       = 4
) (
   input  logic             MasterClock,
   input  logic             reset,
   input  logic [N_CLK-1:0] clkIn,
   input  logic             enable,
   input  logic             divLoad,
   input  logic [DIV_W-1:0] divValue,
   output logic [N_CLK-1:0] clkLvl,
   output logic [N_CLK-1:0] rise,
   output logic [N_CLK-1:0] fall,
   output logic             divClk,
   output logic             divRise,
   output logic             divFall,
   output logic [7:0]       glitchCount
);

   localparam int SUM_W = 8 + $clog2(N_CLK + 1);

   logic [N_CLK-1:0] glitchVec;
   logic [DIV_W-1:0] divCnt;
   logic [DIV_W-1:0] divShadow;
   divState_t        divState;

   for (genvar g = 0; g < N_CLK; g++) begin : gChan
      mc_edge_filter #(
         .SYNC_STAGES(SYNC_STAGES),
         .FILTER     (FILTER)
      ) uFilter (
         .clk   (MasterClock),
         .reset (reset),
         .din   (clkIn[g]),
         .lvl   (clkLvl[g]),
         .rise  (rise[g]),
         .fall  (fall[g]),
         .glitch(glitchVec[g])
      );
   end

   function automatic logic [7:0] satAdd(input logic [7:0] base, input logic [N_CLK-1:0] hits);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(base);
      for (int i = 0; i < N_CLK; i++) begin
         sum = sum + SUM_W'(hits[i]);
      end
      return (sum > SUM_W'(GLITCH_SAT)) ? GLITCH_SAT : sum[7:0];
   endfunction

   always_ff @(posedge MasterClock or posedge reset) begin
      if (reset) begin
         glitchCount <= 8'h00;
      end else begin
         glitchCount <= satAdd(glitchCount, glitchVec);
      end
   end

   assign divState = enable ? ACTIVE : FROZEN;

   // Shadow is only consumed at terminal count, so a load never shortens a half-period.
   always_ff @(posedge MasterClock or posedge reset) begin
      if (reset) begin
         divCnt    <= '0;
         divShadow <= '0;
         divClk    <= 1'b0;
         divRise   <= 1'b0;
         divFall   <= 1'b0;
      end else begin
         if (divLoad) begin
            divShadow <= divValue;
         end
         divRise <= 1'b0;
         divFall <= 1'b0;
         case (divState)
            ACTIVE: begin
               if (divCnt == '0) begin
                  divCnt  <= divShadow;
                  divClk  <= ~divClk;
                  divRise <= ~divClk;
                  divFall <= divClk;
               end else begin
                  divCnt <= divCnt - 1'b1;
               end
            end
            FROZEN: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_clock_strobe_gen.sv
// Directed bench for mc_clock_strobe_gen: edge strobes, glitch counting, divider and reset.
module tb_mc_clock_strobe_gen;

   logic       clk;
   logic       reset;
   logic [3:0] clkIn;
   logic       enable;
   logic       divLoad;
   logic [3:0] divValue;
   logic [3:0] clkLvl;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       divClk;
   logic       divRise;
   logic       divFall;
   logic [7:0] glitchCount;

   int vectors     = 0;
   int miscompares = 0;

   mc_clock_strobe_gen dut (
      .MasterClock(clk),
      .reset      (reset),
      .clkIn      (clkIn),
      .enable     (enable),
      .divLoad    (divLoad),
      .divValue   (divValue),
      .clkLvl     (clkLvl),
      .rise       (rise),
      .fall       (fall),
      .divClk     (divClk),
      .divRise    (divRise),
      .divFall    (divFall),
      .glitchCount(glitchCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      clkIn    = 4'b0000;
      enable   = 1'b0;
      divLoad  = 1'b0;
      divValue = 4'd0;
      step(2);
      chk("rst_lvl", 32'(clkLvl), 32'h0);
      chk("rst_edges", 32'({rise, fall}), 32'h0);
      chk("rst_div", 32'({divClk, divRise, divFall}), 32'h0);
      chk("rst_glitch", 32'(glitchCount), 32'h0);
      reset = 1'b0;
      step(1);
      chk("rel_edges", 32'({rise, fall}), 32'h0);

      // Clean rise on channel 0: strobe after four edges, one cycle wide.
      clkIn[0] = 1'b1;
      step(3);
      chk("r0_early", 32'(rise), 32'h0);
      step(1);
      chk("r0_strobe", 32'(rise), 32'h1);
      chk("r0_lvl", 32'(clkLvl), 32'h1);
      step(1);
      chk("r0_width", 32'(rise), 32'h0);
      chk("r0_hold", 32'(clkLvl), 32'h1);
      chk("r0_noglitch", 32'(glitchCount), 32'h0);

      // Single-sample pulse on channel 1 is rejected and counted.
      clkIn[1] = 1'b1;
      step(1);
      clkIn[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("g1_edges", 32'({rise, fall}), 32'h0);
      end
      chk("g1_count", 32'(glitchCount), 32'h1);
      step(2);
      chk("g1_lvl", 32'(clkLvl), 32'h1);
      for (int k = 0; k < 299; k++) begin
         clkIn[1] = 1'b1;
         step(1);
         clkIn[1] = 1'b0;
         step(1);
      end
      step(4);
      chk("g1_sat", 32'(glitchCount), 32'hFF);
      chk("g1_lvl_end", 32'(clkLvl), 32'h1);

      // Clean fall on channel 0.
      clkIn[0] = 1'b0;
      step(3);
      chk("f0_early", 32'(fall), 32'h0);
      step(1);
      chk("f0_strobe", 32'(fall), 32'h1);
      chk("f0_lvl", 32'(clkLvl), 32'h0);

      // Divider with half-period 4.
      divLoad  = 1'b1;
      divValue = 4'd3;
      step(1);
      divLoad = 1'b0;
      enable  = 1'b1;
      step(1);
      chk("d3_rise1", 32'({divClk, divRise, divFall}), 32'b110);
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("d3_hi", 32'({divClk, divRise, divFall}), 32'b100);
      end
      step(1);
      chk("d3_fall", 32'({divClk, divRise, divFall}), 32'b001);
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("d3_lo", 32'({divClk, divRise, divFall}), 32'b000);
      end
      step(1);
      chk("d3_rise2", 32'({divClk, divRise, divFall}), 32'b110);

      // Reload to 0 mid half-period: current half still lasts 4 cycles.
      step(1);
      divLoad  = 1'b1;
      divValue = 4'd0;
      step(1);
      divLoad = 1'b0;
      step(1);
      chk("d0_hold", 32'({divClk, divRise, divFall}), 32'b100);
      step(1);
      chk("d0_fall", 32'({divClk, divRise, divFall}), 32'b001);
      step(1);
      chk("d0_rise", 32'({divClk, divRise, divFall}), 32'b110);
      step(1);
      chk("d0_fall2", 32'({divClk, divRise, divFall}), 32'b001);
      step(1);
      chk("d0_rise2", 32'({divClk, divRise, divFall}), 32'b110);

      // Load on a terminal-count cycle: that reload still uses the old shadow.
      divLoad  = 1'b1;
      divValue = 4'd3;
      step(1);
      divLoad = 1'b0;
      chk("tc_fall", 32'({divClk, divRise, divFall}), 32'b001);
      step(1);
      chk("tc_oldshadow", 32'({divClk, divRise, divFall}), 32'b110);
      step(2);
      chk("tc_count", 32'({divClk, divRise, divFall}), 32'b100);

      // Freeze with one count left.
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("frz_hold", 32'({divClk, divRise, divFall}), 32'b100);
      end
      enable = 1'b1;
      step(1);
      chk("frz_resume", 32'({divClk, divRise, divFall}), 32'b100);
      step(1);
      chk("frz_fall", 32'({divClk, divRise, divFall}), 32'b001);

      // Reset while a channel-2 rise is pending and divClk is high.
      step(3);
      chk("pre_lo", 32'({divClk, divRise, divFall}), 32'b000);
      step(1);
      chk("pre_rise", 32'({divClk, divRise, divFall}), 32'b110);
      clkIn[2] = 1'b1;
      step(3);
      chk("pre_pending", 32'(rise), 32'h0);
      reset    = 1'b1;
      enable   = 1'b0;
      clkIn    = 4'b0000;
      #1;
      chk("ar_div", 32'({divClk, divRise, divFall}), 32'b000);
      chk("ar_glitch", 32'(glitchCount), 32'h0);
      chk("ar_chan", 32'({clkLvl, rise, fall}), 32'h0);
      step(1);
      reset = 1'b0;
      step(1);
      chk("post_edges", 32'({rise, fall}), 32'h0);
      chk("post_div", 32'({divClk, divRise, divFall}), 32'b000);
      step(4);
      chk("post_quiet", 32'({clkLvl, rise, fall}), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
